// File: rtl/hash_msg_feeder.sv
// Host-side message buffer that streams bytes to the hash core,
// then captures and checks the returned digest.
module hash_msg_feeder #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_ready,
   input  logic        start,
   input  logic [31:0] expected,
   output logic        busy,
   output logic        M_valid,
   output logic [7:0]  M,
   output logic [63:0] C_in,
   input  logic        hash_ready,
   input  logic [31:0] digest,
   output logic        done,
   output logic        match,
   output logic        timeout,
   output logic [31:0] digest_q
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_REPORT
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic          mem_we;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] left_q, left_d;
   logic [TW-1:0] wait_q, wait_d;
   logic [63:0]   c_in_q, c_in_d;
   logic          m_valid_q, m_valid_d;
   logic [7:0]    m_q, m_d;
   logic          match_q, match_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   dig_q, dig_d;
   logic          wr_fire;
   logic [CW-1:0] eff_len;

   assign wr_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
   assign wr_fire  = wr_valid && wr_ready;
   assign eff_len  = count_q + CW'(wr_fire);

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_REPORT);
   assign M_valid  = m_valid_q;
   assign M        = m_q;
   assign C_in     = c_in_q;
   assign match    = match_q;
   assign timeout  = timeout_q;
   assign digest_q = dig_q;

   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      left_d    = left_q;
      wait_d    = wait_q;
      c_in_d    = c_in_q;
      m_valid_d = 1'b0;
      m_d       = 8'h00;
      match_d   = match_q;
      timeout_d = timeout_q;
      dig_d     = dig_q;
      unique case (state_q)
         S_IDLE: begin
            if (wr_fire) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = eff_len;
            end
            if (start && (eff_len != '0)) begin
               state_d   = S_SEND;
               c_in_d    = 64'(eff_len);
               m_valid_d = 1'b1;
               // an empty buffer means the first byte is the one arriving now
               m_d       = (count_q == '0) ? wr_data : mem_q[rd_ptr_q];
               rd_ptr_d  = rd_ptr_q + 1'b1;
               left_d    = eff_len - 1'b1;
            end
         end
         S_SEND: begin
            if (left_q != '0) begin
               m_valid_d = 1'b1;
               m_d       = mem_q[rd_ptr_q];
               rd_ptr_d  = rd_ptr_q + 1'b1;
               left_d    = left_q - 1'b1;
            end else begin
               state_d = S_WAIT;
               wait_d  = '0;
            end
         end
         S_WAIT: begin
            if (hash_ready) begin
               state_d   = S_REPORT;
               dig_d     = digest;
               match_d   = (digest == expected);
               timeout_d = 1'b0;
            end else if (wait_q == TW'(TIMEOUT)) begin
               state_d   = S_REPORT;
               dig_d     = 32'h0;
               match_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_REPORT: begin
            state_d  = S_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            c_in_d   = 64'h0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         left_q    <= '0;
         wait_q    <= '0;
         c_in_q    <= 64'h0;
         m_valid_q <= 1'b0;
         m_q       <= 8'h00;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
         dig_q     <= 32'h0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         left_q    <= left_d;
         wait_q    <= wait_d;
         c_in_q    <= c_in_d;
         m_valid_q <= m_valid_d;
         m_q       <= m_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
         dig_q     <= dig_d;
      end
   end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a timeline model
// and a per-cycle comparator.
module tb_hash_msg_feeder;

   localparam int DEPTH = 16;
   localparam int TOUT  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_ready;
   logic        start = 1'b0;
   logic [31:0] expected = 32'h0;
   logic        busy;
   logic        M_valid;
   logic [7:0]  M;
   logic [63:0] C_in;
   logic        hash_ready = 1'b0;
   logic [31:0] digest = 32'h0;
   logic        done;
   logic        match;
   logic        timeout;
   logic [31:0] digest_q;

   always #5 clk = ~clk;

   hash_msg_feeder #(.DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .start(start), .expected(expected), .busy(busy),
      .M_valid(M_valid), .M(M), .C_in(C_in),
      .hash_ready(hash_ready), .digest(digest),
      .done(done), .match(match), .timeout(timeout),
      .digest_q(digest_q)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Timeline model: a run started on edge t with L bytes streams
   // after edges t..t+L-1, samples hash_ready from edge t+L+1 on.
   logic [7:0]  q[$];
   logic [7:0]  stream[$];
   bit          run;
   int          n, t, L, rep;
   logic [31:0] e_dq;
   logic        e_match, e_to;
   int          cyc = 0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete(); stream.delete();
         run = 0; n = 0; t = 0; L = 0; rep = -1;
         e_dq = 0; e_match = 0; e_to = 0;
      end else begin
         n++;
         if (!run) begin
            if (wr_valid && q.size() < DEPTH) q.push_back(wr_data);
            if (start && q.size() > 0) begin
               run = 1; t = n; L = q.size(); stream = q; rep = -1;
            end
         end else if (rep < 0) begin
            if (n >= t + L + 1) begin
               if (hash_ready) begin
                  rep = n; e_dq = digest;
                  e_match = (digest == expected); e_to = 0;
               end else if (n == t + L + 1 + TOUT) begin
                  rep = n; e_dq = 0; e_match = 0; e_to = 1;
               end
            end
         end else if (n == rep + 1) begin
            run = 0; q.delete();
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   bit         cmp_en = 0;
   logic [7:0] seen[$];
   int         ndone = 0;
   bit         ev;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (M_valid) seen.push_back(M);
         if (done) ndone++;
      end
      if (cmp_en && !rst) begin
         ev = run && (n >= t) && (n <= t + L - 1);
         chk("busy", busy, run);
         chk("M_valid", M_valid, ev);
         if (ev) chk("M", M, stream[n-t]);
         chk("C_in", C_in, run ? 64'(L) : 64'd0);
         chk("done", done, run && rep >= 0 && n == rep);
         chk("wr_ready", wr_ready, !run && q.size() < DEPTH);
         chk("match", match, e_match);
         chk("timeout", timeout, e_to);
         chk("digest_q", digest_q, e_dq);
      end
   end

   task automatic wr(input logic [7:0] b);
      wr_valid = 1; wr_data = b;
      @(negedge clk);
      wr_valid = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_send_end(input string nm);
      int k = 0;
      while (M_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " send end"}, M_valid, 0);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " done seen"}, done, 1);
   endtask

   int went;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst M_valid", M_valid, 0);
      chk("rst M", M, 0);
      chk("rst C_in", C_in, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst dq", digest_q, 0);
      rst = 0; cmp_en = 1;
      @(negedge clk);
      chk("rst wr_ready", wr_ready, 1);

      // basic run
      seen.delete(); ndone = 0;
      expected = 32'h1234_5678; digest = 32'h1234_5678;
      wr(8'h41); wr(8'h42); wr(8'h43);
      pulse_start();
      chk("basic C_in", C_in, 3);
      wait_send_end("basic");
      repeat (2) @(negedge clk);
      hash_ready = 1;
      wait_done("basic");
      hash_ready = 0;
      @(negedge clk);
      chk("basic nbytes", seen.size(), 3);
      for (int i = 0; i < seen.size(); i++)
         chk("basic byte", seen[i], 64'(8'h41 + i));
      chk("basic ndone", ndone, 1);
      chk("basic match", match, 1);
      chk("basic dq", digest_q, 32'h1234_5678);
      chk("basic to", timeout, 0);

      // full buffer, mismatch, hash_ready high during SEND
      seen.delete(); ndone = 0;
      expected = 0; digest = 32'hDEAD_BEEF; hash_ready = 1;
      for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
      chk("full wr_ready", wr_ready, 0);
      wr(8'hEE);
      pulse_start();
      chk("full C_in", C_in, 16);
      wait_done("full");
      hash_ready = 0;
      @(negedge clk);
      chk("full nbytes", seen.size(), 16);
      for (int i = 0; i < seen.size(); i++)
         chk("full byte", seen[i], 64'(8'h10 + i));
      chk("full match", match, 0);
      chk("full dq", digest_q, 32'hDEAD_BEEF);

      // write together with start
      seen.delete(); ndone = 0;
      expected = 32'hCAFE_F00D; digest = 32'hCAFE_F00D;
      wr(8'h01); wr(8'h02);
      wr_valid = 1; wr_data = 8'h03; start = 1;
      @(negedge clk);
      wr_valid = 0; start = 0;
      chk("simul C_in", C_in, 3);
      wait_send_end("simul");
      hash_ready = 1;
      wait_done("simul");
      hash_ready = 0;
      @(negedge clk);
      chk("simul nbytes", seen.size(), 3);
      for (int i = 0; i < seen.size(); i++)
         chk("simul byte", seen[i], 64'(i + 1));
      chk("simul match", match, 1);
      ndone = 0;
      pulse_start();
      repeat (3) begin
         chk("empty busy", busy, 0);
         @(negedge clk);
      end
      chk("empty ndone", ndone, 0);

      // timeout, with start and write ignored during WAIT
      ndone = 0;
      wr(8'h55); wr(8'h66);
      pulse_start();
      wait_send_end("tout");
      went = cyc;
      pulse_start();
      wr(8'h77);
      wait_done("tout");
      chk("tout latency", cyc - went, TOUT + 1);
      @(negedge clk);
      chk("tout ndone", ndone, 1);
      chk("tout flag", timeout, 1);
      chk("tout match", match, 0);
      chk("tout dq", digest_q, 0);
      chk("tout wr_ready", wr_ready, 1);
      pulse_start();
      chk("tout empty busy", busy, 0);

      // async reset in the middle of SEND
      for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i));
      pulse_start();
      @(negedge clk);
      chk("rsend M", M, 8'hA1);
      #1 rst = 1;
      #1;
      chk("rsend M_valid", M_valid, 0);
      chk("rsend busy", busy, 0);
      chk("rsend C_in", C_in, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rsend wr_ready", wr_ready, 1);
      pulse_start();
      chk("rsend no run", busy, 0);
      @(negedge clk);
      chk("rsend no send", M_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

endmodule
